alu_decode_stage: RTL and testbench

ALU_DECODE_STAGE -- requirements
Module: alu_decode_stage

---
 rtl/alu_decode_stage_pkg.sv | 65 ++++++
 rtl/alu_decode_stage_if.sv | 44 ++++
 rtl/alu_decoder.sv | 141 ++++++++++++++
 rtl/alu_decode_stage.sv | 176 +++++++++++++++++
 tb/tb_alu_decode_stage.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_decode_stage_pkg.sv
// ---------------------------------------------------------------------------
// alu_decode_stage_pkg
// Shared constants for the ALU decode stage and the ALU it feeds:
//   DEF_DATA_WIDTH / DEF_ALU_CNTR : default operand and control-code widths
//   aluOp_t                       : ALU operation code table
//   OPC_*                         : RV32I major opcodes understood by the decoder
//   occState_t                    : occupancy of the two-entry skid buffer
//   baseAluOp()                   : funct3 -> ALU op for the R-type/I-type ALU group
// ---------------------------------------------------------------------------
package alu_decode_stage_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ALU_CNTR   = 4;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_OR   = 4'b0010,
        ALU_AND  = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLL  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001,
        ALU_EQ   = 4'b1010,
        ALU_GE   = 4'b1011,
        ALU_LT   = 4'b1100,
        ALU_NE   = 4'b1101,
        ALU_LTU  = 4'b1110,
        ALU_GEU  = 4'b1111
    } aluOp_t;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'b00,
        OCC_MAIN  = 2'b01,
        OCC_BOTH  = 2'b10
    } occState_t;

    // The register and immediate ALU groups share one funct3 encoding; the
    // alternate bit selects SUB over ADD and SRA over SRL.
    function automatic aluOp_t baseAluOp(input logic [2:0] funct3, input logic alt);
        aluOp_t op;
        case (funct3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_decode_stage_if.sv
// ---------------------------------------------------------------------------
// alu_decode_stage_if
// Bundle of every signal between the decode stage, its producer and the ALU.
//   in_valid/in_ready   : input handshake
//   instr, pc, rs1_data, rs2_data : instruction bundle
//   flush               : discard buffered and incoming bundles
//   out_valid/out_ready : output handshake
//   s1, s2, alu_cntr, illegal : decoded bundle
//   issue_cnt           : count of completed output handshakes
// Modports: master = producer/consumer side, slave = the decode stage.
// ---------------------------------------------------------------------------
interface alu_decode_stage_if
    import alu_decode_stage_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ALU_CNTR   = DEF_ALU_CNTR
);

    logic                  in_valid;
    logic                  in_ready;
    logic [31:0]           instr;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] rs1_data;
    logic [DATA_WIDTH-1:0] rs2_data;
    logic                  flush;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] s1;
    logic [DATA_WIDTH-1:0] s2;
    logic [ALU_CNTR-1:0]   alu_cntr;
    logic                  illegal;
    logic [31:0]           issue_cnt;

    modport master (
        output in_valid, instr, pc, rs1_data, rs2_data, flush, out_ready,
        input  in_ready, out_valid, s1, s2, alu_cntr, illegal, issue_cnt
    );

    modport slave (
        input  in_valid, instr, pc, rs1_data, rs2_data, flush, out_ready,
        output in_ready, out_valid, s1, s2, alu_cntr, illegal, issue_cnt
    );

endinterface

// File: rtl/alu_decoder.sv
// ---------------------------------------------------------------------------
// alu_decoder
// Purely combinational RV32I decode of one instruction into ALU operands and
// an ALU operation code.
//   i_instr    : instruction word
//   i_pc       : instruction address (AUIPC operand)
//   i_rs1Data  : register-file read data, source 1
//   i_rs2Data  : register-file read data, source 2
//   o_s1, o_s2 : ALU operands
//   o_aluOp    : ALU operation code
//   o_illegal  : instruction cannot be decoded (operands forced to 0, op ADD)
// Build option: BRANCH_CMP_EN enables decoding of B-type compares; without it
// every branch is reported as illegal.
// ---------------------------------------------------------------------------
module alu_decoder
    import alu_decode_stage_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic [31:0]           i_instr,
    input  logic [DATA_WIDTH-1:0] i_pc,
    input  logic [DATA_WIDTH-1:0] i_rs1Data,
    input  logic [DATA_WIDTH-1:0] i_rs2Data,
    output logic [DATA_WIDTH-1:0] o_s1,
    output logic [DATA_WIDTH-1:0] o_s2,
    output aluOp_t                o_aluOp,
    output logic                  o_illegal
);

    logic [6:0]            w_opcode;
    logic [2:0]            w_funct3;
    logic [6:0]            w_funct7;
    logic [DATA_WIDTH-1:0] w_immI;
    logic [DATA_WIDTH-1:0] w_immS;
    logic [DATA_WIDTH-1:0] w_immU;
    logic [DATA_WIDTH-1:0] w_shamt;
    logic                  w_unusedRsField;
    logic [DATA_WIDTH-1:0] w_s1;
    logic [DATA_WIDTH-1:0] w_s2;
    aluOp_t                w_op;
    logic                  w_illegal;

    // Field extraction and immediate formation; the register index field of
    // rs1 is not needed because its data arrives already read.
    assign w_opcode        = i_instr[6:0];
    assign w_funct3        = i_instr[14:12];
    assign w_funct7        = i_instr[31:25];
    assign w_immI          = DATA_WIDTH'($signed(i_instr[31:20]));
    assign w_immS          = DATA_WIDTH'($signed({i_instr[31:25], i_instr[11:7]}));
    assign w_immU          = DATA_WIDTH'($signed({i_instr[31:12], 12'b0}));
    assign w_shamt         = DATA_WIDTH'(i_instr[24:20]);
    assign w_unusedRsField = ^i_instr[19:15];

    // Main decode. Every path starts from the illegal-safe defaults, and any
    // path that flags the instruction illegal has its operands scrubbed at the
    // end so downstream never sees register data from a bad instruction.
    always_comb begin
        w_s1      = '0;
        w_s2      = '0;
        w_op      = ALU_ADD;
        w_illegal = 1'b0;
        case (w_opcode)
            OPC_RTYPE: begin
                w_s1 = i_rs1Data;
                w_s2 = i_rs2Data;
                if (w_funct7 == 7'b0000000) begin
                    w_op = baseAluOp(w_funct3, 1'b0);
                end else if (w_funct7 == 7'b0100000 &&
                             (w_funct3 == 3'b000 || w_funct3 == 3'b101)) begin
                    w_op = baseAluOp(w_funct3, 1'b1);
                end else begin
                    w_illegal = 1'b1;
                end
            end
            OPC_ITYPE: begin
                w_s1 = i_rs1Data;
                case (w_funct3)
                    3'b001: begin
                        w_s2 = w_shamt;
                        if (w_funct7 == 7'b0000000) w_op = ALU_SLL;
                        else                        w_illegal = 1'b1;
                    end
                    3'b101: begin
                        w_s2 = w_shamt;
                        if (w_funct7 == 7'b0000000)      w_op = ALU_SRL;
                        else if (w_funct7 == 7'b0100000) w_op = ALU_SRA;
                        else                             w_illegal = 1'b1;
                    end
                    default: begin
                        w_s2 = w_immI;
                        w_op = baseAluOp(w_funct3, 1'b0);
                    end
                endcase
            end
            OPC_LUI: begin
                w_s2 = w_immU;
            end
            OPC_AUIPC: begin
                w_s1 = i_pc;
                w_s2 = w_immU;
            end
            OPC_LOAD: begin
                w_s1 = i_rs1Data;
                w_s2 = w_immI;
            end
            OPC_STORE: begin
                w_s1 = i_rs1Data;
                w_s2 = w_immS;
            end
`ifdef BRANCH_CMP_EN
            OPC_BRANCH: begin
                w_s1 = i_rs1Data;
                w_s2 = i_rs2Data;
                case (w_funct3)
                    3'b000:  w_op = ALU_EQ;
                    3'b001:  w_op = ALU_NE;
                    3'b100:  w_op = ALU_LT;
                    3'b101:  w_op = ALU_GE;
                    3'b110:  w_op = ALU_LTU;
                    3'b111:  w_op = ALU_GEU;
                    default: w_illegal = 1'b1;
                endcase
            end
`endif
            default: begin
                w_illegal = 1'b1;
            end
        endcase
        if (w_illegal) begin
            w_s1 = '0;
            w_s2 = '0;
            w_op = ALU_ADD;
        end
    end

    assign o_s1      = w_s1;
    assign o_s2      = w_s2;
    assign o_aluOp   = w_op;
    assign o_illegal = w_illegal;

endmodule

// File: rtl/alu_decode_stage.sv
// ---------------------------------------------------------------------------
// alu_decode_stage
// Decodes an RV32I instruction bundle into ALU operands/control and presents
// it one cycle later through a two-entry (main + skid) buffer, so the stage
// runs at full throughput while in_ready comes straight from a flop.
// Ports:
//   clk    : clock, all state changes on the rising edge
//   rst_n  : asynchronous active-low reset
//   io_bus : alu_decode_stage_if.slave (handshakes, bundle, flush, outputs,
//            issue_cnt)
// Build option: BRANCH_CMP_EN enables B-type compare decoding in alu_decoder.
// ---------------------------------------------------------------------------
module alu_decode_stage
    import alu_decode_stage_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ALU_CNTR   = DEF_ALU_CNTR
) (
    input logic            clk,
    input logic            rst_n,
    alu_decode_stage_if.slave io_bus
);

    logic [DATA_WIDTH-1:0] w_decS1;
    logic [DATA_WIDTH-1:0] w_decS2;
    aluOp_t                w_decOp;
    logic                  w_decIllegal;

    occState_t             r_state;
    occState_t             w_nextState;
    logic                  w_loadMainFromIn;
    logic                  w_loadMainFromSkid;
    logic                  w_loadSkid;
    logic                  w_inReady;
    logic                  w_outValid;
    logic                  w_inFire;
    logic                  w_outFire;

    logic [DATA_WIDTH-1:0] r_mainS1;
    logic [DATA_WIDTH-1:0] r_mainS2;
    logic [ALU_CNTR-1:0]   r_mainOp;
    logic                  r_mainIllegal;
    logic [DATA_WIDTH-1:0] r_skidS1;
    logic [DATA_WIDTH-1:0] r_skidS2;
    logic [ALU_CNTR-1:0]   r_skidOp;
    logic                  r_skidIllegal;
    logic [31:0]           r_issueCnt;

    // Decode happens ahead of the buffer so both entries hold finished results.
    alu_decoder #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_decoder (
        .i_instr   (io_bus.instr),
        .i_pc      (io_bus.pc),
        .i_rs1Data (io_bus.rs1_data),
        .i_rs2Data (io_bus.rs2_data),
        .o_s1      (w_decS1),
        .o_s2      (w_decS2),
        .o_aluOp   (w_decOp),
        .o_illegal (w_decIllegal)
    );

    // Both handshake flags are decoded from the occupancy flop only, so
    // in_ready has no combinational path from out_ready or flush.
    assign w_inReady  = (r_state != OCC_BOTH);
    assign w_outValid = (r_state != OCC_EMPTY);
    assign w_inFire   = io_bus.in_valid && w_inReady && !io_bus.flush;
    assign w_outFire  = w_outValid && io_bus.out_ready;

    // Occupancy state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= OCC_EMPTY;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next occupancy and entry load strobes. Flush beats everything; otherwise
    // a new bundle goes to main when main is empty or leaving this cycle, and
    // to skid only when main is stalled. When main leaves while skid is full
    // the skid entry slides forward, which keeps acceptance order.
    always_comb begin
        w_nextState        = r_state;
        w_loadMainFromIn   = 1'b0;
        w_loadMainFromSkid = 1'b0;
        w_loadSkid         = 1'b0;
        if (io_bus.flush) begin
            w_nextState = OCC_EMPTY;
        end else begin
            case (r_state)
                OCC_EMPTY: begin
                    if (w_inFire) begin
                        w_nextState      = OCC_MAIN;
                        w_loadMainFromIn = 1'b1;
                    end
                end
                OCC_MAIN: begin
                    case ({w_outFire, w_inFire})
                        2'b11: w_loadMainFromIn = 1'b1;
                        2'b10: w_nextState      = OCC_EMPTY;
                        2'b01: begin
                            w_nextState = OCC_BOTH;
                            w_loadSkid  = 1'b1;
                        end
                        default: ;
                    endcase
                end
                OCC_BOTH: begin
                    if (w_outFire) begin
                        w_nextState        = OCC_MAIN;
                        w_loadMainFromSkid = 1'b1;
                    end
                end
                default: begin
                    w_nextState = OCC_EMPTY;
                end
            endcase
        end
    end

    // Main entry data. It is only written on a load strobe, so a stalled
    // output keeps every field stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mainS1      <= '0;
            r_mainS2      <= '0;
            r_mainOp      <= '0;
            r_mainIllegal <= 1'b0;
        end else if (w_loadMainFromIn) begin
            r_mainS1      <= w_decS1;
            r_mainS2      <= w_decS2;
            r_mainOp      <= ALU_CNTR'(w_decOp);
            r_mainIllegal <= w_decIllegal;
        end else if (w_loadMainFromSkid) begin
            r_mainS1      <= r_skidS1;
            r_mainS2      <= r_skidS2;
            r_mainOp      <= r_skidOp;
            r_mainIllegal <= r_skidIllegal;
        end
    end

    // Skid entry data, captured only when main is stalled and a bundle arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_skidS1      <= '0;
            r_skidS2      <= '0;
            r_skidOp      <= '0;
            r_skidIllegal <= 1'b0;
        end else if (w_loadSkid) begin
            r_skidS1      <= w_decS1;
            r_skidS2      <= w_decS2;
            r_skidOp      <= ALU_CNTR'(w_decOp);
            r_skidIllegal <= w_decIllegal;
        end
    end

    // Issue counter. A handshake completed in a flush cycle still counts,
    // since the consumer really took that bundle; wraps naturally at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_issueCnt <= '0;
        end else if (w_outFire) begin
            r_issueCnt <= r_issueCnt + 32'd1;
        end
    end

    assign io_bus.in_ready  = w_inReady;
    assign io_bus.out_valid = w_outValid;
    assign io_bus.s1        = r_mainS1;
    assign io_bus.s2        = r_mainS2;
    assign io_bus.alu_cntr  = r_mainOp;
    assign io_bus.illegal   = r_mainIllegal;
    assign io_bus.issue_cnt = r_issueCnt;

endmodule

// File: tb/tb_alu_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_decode_stage
// Directed testbench for alu_decode_stage: reset values, decode of the main
// instruction classes, back-pressure through the skid entry, flush priority
// and reset in the middle of a stall. Honours BRANCH_CMP_EN for B-type vectors.
// ---------------------------------------------------------------------------
module tb_alu_decode_stage;

    logic        clk;
    logic        rst_n;
    int          assertCount;
    int          failCount;
    logic [31:0] expIssue;

    alu_decode_stage_if bus ();

    alu_decode_stage dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so a broken design can never hang the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance to just after the next rising edge, where outputs are sampled
    // and new inputs are driven.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] ins,
                                 input logic [31:0] pcVal, input logic [31:0] a,
                                 input logic [31:0] b);
        bus.in_valid = v;
        bus.instr    = ins;
        bus.pc       = pcVal;
        bus.rs1_data = a;
        bus.rs2_data = b;
    endtask

    task automatic applyReset();
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        rst_n        = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        rst_n = 1'b0;
        #2;
        assertCount++; if (bus.out_valid !== 1'b0) begin failCount++; $display("[TB] FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        assertCount++; if (bus.in_ready !== 1'b1) begin failCount++; $display("[TB] FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
        assertCount++; if (bus.s1 !== 32'h0) begin failCount++; $display("[TB] FAIL reset_s1: got %h expected 0", bus.s1); end
        assertCount++; if (bus.s2 !== 32'h0) begin failCount++; $display("[TB] FAIL reset_s2: got %h expected 0", bus.s2); end
        assertCount++; if (bus.alu_cntr !== 4'b0000) begin failCount++; $display("[TB] FAIL reset_alu_cntr: got %b expected 0000", bus.alu_cntr); end
        assertCount++; if (bus.illegal !== 1'b0) begin failCount++; $display("[TB] FAIL reset_illegal: got %b expected 0", bus.illegal); end
        assertCount++; if (bus.issue_cnt !== 32'h0) begin failCount++; $display("[TB] FAIL reset_issue_cnt: got %0d expected 0", bus.issue_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        expIssue = 32'd0;
    endtask

    task automatic test_sub();
        bus.out_ready = 1'b1;
        applyStimulus(1'b1, 32'h40B50533, 32'h0, 32'd30, 32'd10);
        tick();
        assertCount++; if (bus.out_valid !== 1'b1) begin failCount++; $display("[TB] FAIL sub_out_valid: got %b expected 1", bus.out_valid); end
        assertCount++; if (bus.alu_cntr !== 4'b0001) begin failCount++; $display("[TB] FAIL sub_alu_cntr: got %b expected 0001", bus.alu_cntr); end
        assertCount++; if (bus.s1 !== 32'd30) begin failCount++; $display("[TB] FAIL sub_s1: got %0d expected 30", bus.s1); end
        assertCount++; if (bus.s2 !== 32'd10) begin failCount++; $display("[TB] FAIL sub_s2: got %0d expected 10", bus.s2); end
        assertCount++; if ((bus.s1 - bus.s2) !== 32'd20) begin failCount++; $display("[TB] FAIL sub_alu_result: got %0d expected 20", bus.s1 - bus.s2); end
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        expIssue = expIssue + 32'd1;
        assertCount++; if (bus.out_valid !== 1'b0) begin failCount++; $display("[TB] FAIL sub_drain_valid: got %b expected 0", bus.out_valid); end
        assertCount++; if (bus.issue_cnt !== expIssue) begin failCount++; $display("[TB] FAIL sub_issue_cnt: got %0d expected %0d", bus.issue_cnt, expIssue); end
    endtask

    task automatic test_addi_srai();
        logic [31:0] aluRes;
        bus.out_ready = 1'b1;
        applyStimulus(1'b1, 32'hFFF00093, 32'h0, 32'h80000000, 32'h0);
        tick();
        assertCount++; if (bus.alu_cntr !== 4'b0000) begin failCount++; $display("[TB] FAIL addi_alu_cntr: got %b expected 0000", bus.alu_cntr); end
        assertCount++; if (bus.s1 !== 32'h80000000) begin failCount++; $display("[TB] FAIL addi_s1: got %h expected 80000000", bus.s1); end
        assertCount++; if (bus.s2 !== 32'hFFFFFFFF) begin failCount++; $display("[TB] FAIL addi_s2: got %h expected ffffffff", bus.s2); end
        assertCount++; if (bus.in_ready !== 1'b1) begin failCount++; $display("[TB] FAIL addi_in_ready: got %b expected 1", bus.in_ready); end
        applyStimulus(1'b1, 32'h40435293, 32'h0, 32'h80000000, 32'h0);
        tick();
        aluRes = 32'($signed(bus.s1) >>> bus.s2[4:0]);
        assertCount++; if (bus.out_valid !== 1'b1) begin failCount++; $display("[TB] FAIL srai_out_valid: got %b expected 1", bus.out_valid); end
        assertCount++; if (bus.alu_cntr !== 4'b0111) begin failCount++; $display("[TB] FAIL srai_alu_cntr: got %b expected 0111", bus.alu_cntr); end
        assertCount++; if (bus.s2 !== 32'd4) begin failCount++; $display("[TB] FAIL srai_s2: got %h expected 4", bus.s2); end
        assertCount++; if (aluRes !== 32'hF8000000) begin failCount++; $display("[TB] FAIL srai_alu_result: got %h expected f8000000", aluRes); end
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        expIssue = expIssue + 32'd2;
        assertCount++; if (bus.issue_cnt !== expIssue) begin failCount++; $display("[TB] FAIL srai_issue_cnt: got %0d expected %0d", bus.issue_cnt, expIssue); end
    endtask

    // Streams a table of hand-decoded instructions at full rate; each result
    // must appear exactly one cycle after its bundle was accepted.
    task automatic test_decode_table();
        logic [31:0] tIns [12];
        logic [3:0]  tOp  [12];
        logic [31:0] tS1  [12];
        logic [31:0] tS2  [12];
        logic        tIll [12];
        tIns = '{32'h123450B7, 32'h12345097, 32'hFFC52083, 32'hFE252C23,
                 32'h00B53533, 32'h02B50533, 32'h0000007F, 32'h02051093,
                 32'h00208063, 32'h0F056093, 32'h00202063, 32'h00455093};
        tOp  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1001, 4'b0000,
                 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0110};
        tS1  = '{32'h0, 32'h1000, 32'h11, 32'h11, 32'h11, 32'h0,
                 32'h0, 32'h0, 32'h0, 32'h11, 32'h0, 32'h11};
        tS2  = '{32'h12345000, 32'h12345000, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h22, 32'h0,
                 32'h0, 32'h0, 32'h0, 32'hF0, 32'h0, 32'h4};
        tIll = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
`ifdef BRANCH_CMP_EN
        tOp[8]  = 4'b1010;
        tS1[8]  = 32'h11;
        tS2[8]  = 32'h22;
        tIll[8] = 1'b0;
`endif
        bus.out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, tIns[i], 32'h1000, 32'h11, 32'h22);
            tick();
            assertCount++; if (bus.alu_cntr !== tOp[i]) begin failCount++; $display("[TB] FAIL table%0d_alu_cntr: got %b expected %b", i, bus.alu_cntr, tOp[i]); end
            assertCount++; if (bus.s1 !== tS1[i]) begin failCount++; $display("[TB] FAIL table%0d_s1: got %h expected %h", i, bus.s1, tS1[i]); end
            assertCount++; if (bus.s2 !== tS2[i]) begin failCount++; $display("[TB] FAIL table%0d_s2: got %h expected %h", i, bus.s2, tS2[i]); end
            assertCount++; if (bus.illegal !== tIll[i]) begin failCount++; $display("[TB] FAIL table%0d_illegal: got %b expected %b", i, bus.illegal, tIll[i]); end
            assertCount++; if (bus.out_valid !== 1'b1) begin failCount++; $display("[TB] FAIL table%0d_out_valid: got %b expected 1", i, bus.out_valid); end
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        expIssue = expIssue + 32'd12;
        assertCount++; if (bus.issue_cnt !== expIssue) begin failCount++; $display("[TB] FAIL table_issue_cnt: got %0d expected %0d", bus.issue_cnt, expIssue); end
    endtask

    // Three ADDI bundles tagged by immediate 1/2/3 against a stalled output.
    task automatic test_back_to_back();
        applyReset();
        expIssue = 32'd0;
        bus.out_ready = 1'b0;
        applyStimulus(1'b1, 32'h00100093, 32'h0, 32'h0, 32'h0);
        tick();
        assertCount++; if (bus.in_ready !== 1'b1) begin failCount++; $display("[TB] FAIL b2b_ready_after_one: got %b expected 1", bus.in_ready); end
        assertCount++; if (bus.s2 !== 32'd1) begin failCount++; $display("[TB] FAIL b2b_first_s2: got %0d expected 1", bus.s2); end
        applyStimulus(1'b1, 32'h00200093, 32'h0, 32'h0, 32'h0);
        tick();
        assertCount++; if (bus.in_ready !== 1'b0) begin failCount++; $display("[TB] FAIL b2b_ready_after_two: got %b expected 0", bus.in_ready); end
        assertCount++; if (bus.s2 !== 32'd1) begin failCount++; $display("[TB] FAIL b2b_hold_s2: got %0d expected 1", bus.s2); end
        applyStimulus(1'b1, 32'h00300093, 32'h0, 32'h0, 32'h0);
        tick();
        assertCount++; if (bus.in_ready !== 1'b0) begin failCount++; $display("[TB] FAIL b2b_ready_stalled: got %b expected 0", bus.in_ready); end
        assertCount++; if (bus.out_valid !== 1'b1 || bus.s2 !== 32'd1) begin failCount++; $display("[TB] FAIL b2b_stall_hold: got valid=%b s2=%0d expected valid=1 s2=1", bus.out_valid, bus.s2); end
        bus.out_ready = 1'b1;
        tick();
        assertCount++; if (bus.s2 !== 32'd2) begin failCount++; $display("[TB] FAIL b2b_second_s2: got %0d expected 2", bus.s2); end
        assertCount++; if (bus.in_ready !== 1'b1) begin failCount++; $display("[TB] FAIL b2b_ready_rise: got %b expected 1", bus.in_ready); end
        tick();
        assertCount++; if (bus.out_valid !== 1'b1 || bus.s2 !== 32'd3) begin failCount++; $display("[TB] FAIL b2b_third: got valid=%b s2=%0d expected valid=1 s2=3", bus.out_valid, bus.s2); end
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        expIssue = 32'd3;
        assertCount++; if (bus.out_valid !== 1'b0) begin failCount++; $display("[TB] FAIL b2b_drained: got %b expected 0", bus.out_valid); end
        assertCount++; if (bus.issue_cnt !== 32'd3) begin failCount++; $display("[TB] FAIL b2b_issue_cnt: got %0d expected 3", bus.issue_cnt); end
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        applyStimulus(1'b1, 32'h00400093, 32'h0, 32'h0, 32'h0);
        tick();
        applyStimulus(1'b1, 32'h00500093, 32'h0, 32'h0, 32'h0);
        tick();
        assertCount++; if (bus.in_ready !== 1'b0) begin failCount++; $display("[TB] FAIL flush_full_before: got %b expected 0", bus.in_ready); end
        applyStimulus(1'b1, 32'h00600093, 32'h0, 32'h0, 32'h0);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        assertCount++; if (bus.out_valid !== 1'b0) begin failCount++; $display("[TB] FAIL flush_out_valid: got %b expected 0", bus.out_valid); end
        assertCount++; if (bus.in_ready !== 1'b1) begin failCount++; $display("[TB] FAIL flush_in_ready: got %b expected 1", bus.in_ready); end
        bus.out_ready = 1'b1;
        tick();
        assertCount++; if (bus.out_valid !== 1'b0) begin failCount++; $display("[TB] FAIL flush_no_stale: got %b expected 0", bus.out_valid); end
        assertCount++; if (bus.issue_cnt !== expIssue) begin failCount++; $display("[TB] FAIL flush_issue_held: got %0d expected %0d", bus.issue_cnt, expIssue); end
        // Flush coinciding with an output handshake and a new input.
        applyStimulus(1'b1, 32'h00700093, 32'h0, 32'h0, 32'h0);
        tick();
        applyStimulus(1'b1, 32'h00800093, 32'h0, 32'h0, 32'h0);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        expIssue = expIssue + 32'd1;
        assertCount++; if (bus.out_valid !== 1'b0) begin failCount++; $display("[TB] FAIL flush_hs_out_valid: got %b expected 0", bus.out_valid); end
        assertCount++; if (bus.issue_cnt !== expIssue) begin failCount++; $display("[TB] FAIL flush_hs_issue_cnt: got %0d expected %0d", bus.issue_cnt, expIssue); end
        tick();
        assertCount++; if (bus.out_valid !== 1'b0) begin failCount++; $display("[TB] FAIL flush_input_dropped: got %b expected 0", bus.out_valid); end
        applyStimulus(1'b1, 32'h00900093, 32'h0, 32'h0, 32'h0);
        tick();
        assertCount++; if (bus.out_valid !== 1'b1 || bus.s2 !== 32'd9) begin failCount++; $display("[TB] FAIL flush_recover: got valid=%b s2=%0d expected valid=1 s2=9", bus.out_valid, bus.s2); end
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        expIssue = expIssue + 32'd1;
        assertCount++; if (bus.issue_cnt !== expIssue) begin failCount++; $display("[TB] FAIL flush_final_issue: got %0d expected %0d", bus.issue_cnt, expIssue); end
    endtask

    task automatic test_reset_mid_stall();
        bus.out_ready = 1'b0;
        applyStimulus(1'b1, 32'h40B50533, 32'h0, 32'd30, 32'd10);
        tick();
        applyStimulus(1'b1, 32'h00200093, 32'h0, 32'h0, 32'h0);
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        assertCount++; if (bus.out_valid !== 1'b0) begin failCount++; $display("[TB] FAIL rststall_out_valid: got %b expected 0", bus.out_valid); end
        assertCount++; if (bus.in_ready !== 1'b1) begin failCount++; $display("[TB] FAIL rststall_in_ready: got %b expected 1", bus.in_ready); end
        assertCount++; if (bus.s1 !== 32'h0 || bus.s2 !== 32'h0) begin failCount++; $display("[TB] FAIL rststall_operands: got s1=%h s2=%h expected 0 0", bus.s1, bus.s2); end
        assertCount++; if (bus.alu_cntr !== 4'b0000 || bus.illegal !== 1'b0) begin failCount++; $display("[TB] FAIL rststall_ctrl: got alu=%b ill=%b expected 0000 0", bus.alu_cntr, bus.illegal); end
        assertCount++; if (bus.issue_cnt !== 32'h0) begin failCount++; $display("[TB] FAIL rststall_issue_cnt: got %0d expected 0", bus.issue_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        applyStimulus(1'b1, 32'h05500093, 32'h0, 32'h0, 32'h0);
        tick();
        assertCount++; if (bus.out_valid !== 1'b1 || bus.s2 !== 32'h55) begin failCount++; $display("[TB] FAIL rststall_first_accept: got valid=%b s2=%h expected valid=1 s2=55", bus.out_valid, bus.s2); end
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        assertCount++; if (bus.issue_cnt !== 32'd1) begin failCount++; $display("[TB] FAIL rststall_issue_after: got %0d expected 1", bus.issue_cnt); end
    endtask

    // Scenario sequence followed by the one-line summary.
    initial begin
        assertCount = 0;
        failCount   = 0;
        expIssue    = 32'd0;
        rst_n       = 1'b0;
        test_reset();
        test_sub();
        test_addi_srai();
        test_decode_table();
        test_back_to_back();
        test_flush();
        test_reset_mid_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
